bet_arbiter: RTL and testbench

Arbiter and sequencer for the single-port, 1-bit-wide Block Erase Table (BET) RAM. It shares the RAM between two requesters: port 0 is the write-path flag setter, and port 1 is the wear-leveling scanner. It also provides a bulk-clear sweep. Every access is a read-modify-write, so the block keeps a live count of set flags (`flag_count`) for the wear-leveling ratio logic.

---
 rtl/bet_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bet_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bet_arbiter.sv
// Block Erase Table arbiter: shares the single-port 1-bit BET RAM between the flag setter (port 0)
// and the wear-leveling scanner (port 1), runs bulk clears, and tracks the count of set flags.
`timescale 1ns/1ps
module bet_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned BET_SIZE = 4096
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_we,
  input  logic              p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_we,
  input  logic              p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w,
  output logic              ram_w_en,
  input  logic              ram_r,
  output logic [ADDR_W:0]   flag_count
);

  localparam logic [ADDR_W:0] FullCnt = (ADDR_W+1)'(BET_SIZE);
  localparam logic [ADDR_W:0] CntOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LastCnt = FullCnt - CntOne;

  // StDoneQ is the done cycle; it arbitrates exactly like StIdle so accesses can run back to back.
  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDoneQ, StClr} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        rdata_q, rdata_d;
  logic              clr_busy_q, clr_busy_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_w_q, ram_w_d;
  logic              ram_w_en_q, ram_w_en_d;
  logic [ADDR_W:0]   flag_count_q, flag_count_d;
  logic              pick;

  // On a tie the port not granted last wins; otherwise whichever port is requesting.
  assign pick = (p0_req && p1_req) ? ~last_grant_q : p1_req;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    gnt_d        = 2'b00;
    done_d       = 2'b00;
    rdata_d      = rdata_q;
    clr_busy_d   = clr_busy_q;
    clr_cnt_d    = clr_cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_w_d      = ram_w_q;
    ram_w_en_d   = 1'b0;
    flag_count_d = flag_count_q;

    case (state_q)
      StIdle, StDoneQ: begin
        if (clr_req) begin
          state_d    = StClr;
          clr_busy_d = 1'b1;
          clr_cnt_d  = CntOne;
          ram_addr_d = '0;
          ram_w_d    = 1'b0;
          ram_w_en_d = 1'b1;
        end else if (p0_req || p1_req) begin
          state_d       = StRd;
          last_grant_d  = pick;
          port_d        = pick;
          addr_d        = pick ? p1_addr : p0_addr;
          we_d          = pick ? p1_we : p0_we;
          wdata_d       = pick ? p1_wdata : p0_wdata;
          ram_addr_d    = pick ? p1_addr : p0_addr;
          gnt_d[pick]   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        rdata_d[port_q] = ram_r;
        if (we_q && (wdata_q != ram_r)) begin
          state_d    = StWr;
          ram_w_d    = wdata_q;
          ram_w_en_d = 1'b1;
        end else begin
          done_d[port_q] = 1'b1;
          state_d        = StDoneQ;
        end
      end
      StWr: begin
        // Saturate so an uncleared RAM after power-up cannot wrap the count.
        if (wdata_q) begin
          if (flag_count_q != FullCnt) flag_count_d = flag_count_q + CntOne;
        end else if (flag_count_q != '0) begin
          flag_count_d = flag_count_q - CntOne;
        end
        done_d[port_q] = 1'b1;
        state_d        = StDoneQ;
      end
      StClr: begin
        if (clr_cnt_q == FullCnt) begin
          clr_busy_d = 1'b0;
          state_d    = StIdle;
        end else begin
          ram_addr_d = clr_cnt_q[ADDR_W-1:0];
          ram_w_d    = 1'b0;
          ram_w_en_d = 1'b1;
          clr_cnt_d  = clr_cnt_q + CntOne;
          if (clr_cnt_q == LastCnt) flag_count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= 1'b0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      rdata_q      <= 2'b00;
      clr_busy_q   <= 1'b0;
      clr_cnt_q    <= '0;
      ram_addr_q   <= '0;
      ram_w_q      <= 1'b0;
      ram_w_en_q   <= 1'b0;
      flag_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      clr_busy_q   <= clr_busy_d;
      clr_cnt_q    <= clr_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_w_q      <= ram_w_d;
      ram_w_en_q   <= ram_w_en_d;
      flag_count_q <= flag_count_d;
    end
  end

  assign p0_gnt     = gnt_q[0];
  assign p1_gnt     = gnt_q[1];
  assign p0_done    = done_q[0];
  assign p1_done    = done_q[1];
  assign p0_rdata   = rdata_q[0];
  assign p1_rdata   = rdata_q[1];
  assign clr_busy   = clr_busy_q;
  assign ram_addr   = ram_addr_q;
  assign ram_w      = ram_w_q;
  assign ram_w_en   = ram_w_en_q;
  assign flag_count = flag_count_q;

endmodule

// File: tb/tb_bet_arbiter.sv
// Bench for bet_arbiter: a behavioural BET RAM plus a flag/count/round-robin reference model.
`timescale 1ns/1ps
module tb_bet_arbiter;
  localparam int AW = 12;
  localparam int N  = 4096;

  logic          clk_50 = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p0_wdata = 1'b0;
  logic          p1_req = 1'b0, p1_we = 1'b0, p1_wdata = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic          p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata;
  logic          clr_req = 1'b0, clr_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_w, ram_w_en;
  logic          ram_r = 1'b0;
  logic [AW:0]   flag_count;

  int vectors = 0;
  int miscompares = 0;

  logic mem [N];
  logic ref_mem [N];
  int   ref_cnt = 0;
  int   ref_last = 1;

  bet_arbiter #(.ADDR_W(AW), .BET_SIZE(N)) dut (
    .clk_50(clk_50), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_w(ram_w), .ram_w_en(ram_w_en), .ram_r(ram_r),
    .flag_count(flag_count)
  );

  always #5 clk_50 = ~clk_50;

  // Synchronous-read single-port RAM.
  always @(posedge clk_50) begin
    if (ram_w_en) mem[ram_addr] <= ram_w;
    ram_r <= mem[ram_addr];
  end

  // One access on one port; times are negedge counts after the request is raised.
  task automatic access(input int port, input logic [AW-1:0] a, input logic we, input logic wd,
                        output int t_gnt, output int t_wen, output int t_done, output int n_wen,
                        output logic rd);
    t_gnt = -1; t_wen = -1; t_done = -1; n_wen = 0; rd = 1'bx;
    if (port == 0) begin p0_addr = a; p0_we = we; p0_wdata = wd; p0_req = 1'b1; end
    else           begin p1_addr = a; p1_we = we; p1_wdata = wd; p1_req = 1'b1; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_50);
      if (((port == 0) ? p0_gnt : p1_gnt) && t_gnt < 0) begin
        t_gnt = k; p0_req = 1'b0; p1_req = 1'b0;
      end
      if (ram_w_en) begin n_wen++; if (t_wen < 0) t_wen = k; end
      if ((port == 0) ? p0_done : p1_done) begin
        t_done = k; rd = (port == 0) ? p0_rdata : p1_rdata;
        break;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50);
    vectors++;
    if ({p0_gnt, p1_gnt, p0_done, p1_done, p0_rdata, p1_rdata, clr_busy, ram_w_en, ram_w}
        !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 0", {p0_gnt, p1_gnt, p0_done, p1_done,
               p0_rdata, p1_rdata, clr_busy, ram_w_en, ram_w});
    end
    rst = 1'b1;
    @(negedge clk_50);
    vectors++;
    if (ram_addr !== '0) begin
      miscompares++; $display("FAIL reset_addr: got %h, required 0", ram_addr);
    end
    vectors++;
    if (flag_count !== '0) begin
      miscompares++; $display("FAIL reset_count: got %0d, required 0", flag_count);
    end
  endtask

  task automatic test_clear();
    int nwr = 0, busy = 0, first = -1, bad = 0, nz = 0;
    clr_req = 1'b1;
    for (int k = 1; k <= N + 20; k++) begin
      @(negedge clk_50);
      if (k == 1) clr_req = 1'b0;
      if (ram_w_en) begin
        if (ram_addr !== AW'(nwr) || ram_w !== 1'b0) bad++;
        if (first < 0) first = k;
        nwr++;
      end
      if (clr_busy) busy++;
      if (nwr > 0 && !ram_w_en && !clr_busy) break;
    end
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = 1'b0;
      if (mem[i] !== 1'b0) nz++;
    end
    ref_cnt = 0;
    vectors++;
    if (nwr != N || first != 1 || bad != 0) begin
      miscompares++;
      $display("FAIL clear_writes: got %0d writes first@%0d %0d bad, required %0d first@1 0 bad",
               nwr, first, bad, N);
    end
    vectors++;
    if (busy != N) begin
      miscompares++; $display("FAIL clear_busy: got %0d cycles, required %0d", busy, N);
    end
    vectors++;
    if (nz != 0 || flag_count !== (AW+1)'(ref_cnt)) begin
      miscompares++;
      $display("FAIL clear_result: %0d set entries count %0d, required 0 and 0", nz, flag_count);
    end
  endtask

  task automatic test_directed();
    int tg, tw, td, nw;
    logic rd;
    access(0, 12'h123, 1'b1, 1'b1, tg, tw, td, nw, rd);
    vectors++;
    if (tg != 1 || tw != 3 || td != 4 || nw != 1) begin
      miscompares++;
      $display("FAIL p0_set_timing: gnt@%0d wen@%0d done@%0d nwen %0d, required 1 3 4 1",
               tg, tw, td, nw);
    end
    vectors++;
    if (rd !== 1'b0 || flag_count !== 13'd1) begin
      miscompares++; $display("FAIL p0_set_data: rdata %b count %0d, required 0 1", rd, flag_count);
    end
    ref_mem[12'h123] = 1'b1; ref_cnt = 1; ref_last = 0;
    access(1, 12'h123, 1'b0, 1'b0, tg, tw, td, nw, rd);
    vectors++;
    if (tg != 1 || td != 3 || nw != 0 || rd !== 1'b1) begin
      miscompares++;
      $display("FAIL p1_read: gnt@%0d done@%0d nwen %0d rdata %b, required 1 3 0 1",
               tg, td, nw, rd);
    end
    ref_last = 1;
    access(0, 12'h123, 1'b1, 1'b1, tg, tw, td, nw, rd);
    vectors++;
    if (td != 3 || nw != 0 || rd !== 1'b1 || flag_count !== 13'd1) begin
      miscompares++;
      $display("FAIL p0_nochange: done@%0d nwen %0d rdata %b count %0d, required 3 0 1 1",
               td, nw, rd, flag_count);
    end
    ref_last = 0;
  endtask

  task automatic test_random();
    int tg, tw, td, nw, port, exp_done, exp_wen;
    logic rd, we, wd, old, chg;
    logic [AW-1:0] a;
    for (int i = 0; i < 150; i++) begin
      port = int'($urandom_range(0, 1));
      a    = AW'(12'h200 + $urandom_range(0, 15));
      we   = ($urandom_range(0, 3) != 0);
      wd   = 1'($urandom_range(0, 1));
      old  = ref_mem[a];
      chg  = we && (wd != old);
      exp_done = chg ? 4 : 3;
      exp_wen  = chg ? 1 : 0;
      access(port, a, we, wd, tg, tw, td, nw, rd);
      if (chg) begin
        ref_mem[a] = wd;
        if (wd) ref_cnt = (ref_cnt < N) ? ref_cnt + 1 : N;
        else    ref_cnt = (ref_cnt > 0) ? ref_cnt - 1 : 0;
      end
      ref_last = port;
      vectors++;
      if (tg != 1 || td != exp_done || nw != exp_wen || rd !== old) begin
        miscompares++;
        $display("FAIL random_access[%0d] p%0d @%h: gnt@%0d done@%0d nwen %0d rdata %b, required 1 %0d %0d %b",
                 i, port, a, tg, td, nw, rd, exp_done, exp_wen, old);
      end
      vectors++;
      if (flag_count !== (AW+1)'(ref_cnt) || mem[a] !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL random_state[%0d]: count %0d flag %b, required %0d %b",
                 i, flag_count, mem[a], ref_cnt, ref_mem[a]);
      end
    end
  endtask

  task automatic test_round_robin();
    int g[$];
    int clr_at = -1, overlap = 0;
    logic raised = 1'b0;
    p0_addr = 12'h010; p0_we = 1'b0; p1_addr = 12'h020; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk_50);
      if (clr_busy && (p0_gnt || p1_gnt)) overlap++;
      if (p0_gnt) g.push_back(0);
      if (p1_gnt) g.push_back(1);
      if (g.size() == 4 && !raised) begin clr_req = 1'b1; raised = 1'b1; end
      if (clr_busy && clr_at < 0) begin clr_at = g.size(); clr_req = 1'b0; end
      if (g.size() == 8) break;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (6) @(negedge clk_50);
    vectors++;
    if (g.size() != 8) begin
      miscompares++; $display("FAIL rr_count: got %0d grants, required 8", g.size());
    end
    for (int i = 0; i < g.size(); i++) begin
      vectors++;
      if (g[i] != (ref_last + 1 + i) % 2) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got p%0d, required p%0d", i, g[i], (ref_last + 1 + i) % 2);
      end
    end
    vectors++;
    if (clr_at != 4 || overlap != 0) begin
      miscompares++;
      $display("FAIL rr_clear: sweep after %0d grants overlap %0d, required 4 and 0",
               clr_at, overlap);
    end
    if (g.size() > 0) ref_last = g[g.size()-1];
    for (int i = 0; i < N; i++) ref_mem[i] = 1'b0;
    ref_cnt = 0;
  endtask

  task automatic test_reset_mid_write();
    int tg, tw, td, nw, nd = 0, first = -1;
    logic rd;
    access(1, 12'h0B0, 1'b1, 1'b1, tg, tw, td, nw, rd);
    ref_mem[12'h0B0] = 1'b1; ref_cnt = 1; ref_last = 1;
    vectors++;
    if (flag_count !== (AW+1)'(ref_cnt)) begin
      miscompares++; $display("FAIL prewrite_count: got %0d, required 1", flag_count);
    end
    p0_addr = 12'h0A5; p0_we = 1'b1; p0_wdata = 1'b1; p0_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_50);
      if (p0_gnt) p0_req = 1'b0;
      if (ram_w_en) break;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (ram_w_en !== 1'b0 || flag_count !== '0) begin
      miscompares++;
      $display("FAIL reset_in_wr: wen %b count %0d, required 0 0", ram_w_en, flag_count);
    end
    ref_cnt = 0; ref_last = 1;
    repeat (2) @(negedge clk_50);
    rst = 1'b1;
    // Tie straight after reset: port 0 must win.
    p0_we = 1'b0; p1_we = 1'b0; p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_50);
      if (p0_done || p1_done) nd++;
      if (p0_gnt && first < 0) first = 0;
      if (p1_gnt && first < 0) first = 1;
      if (first >= 0) break;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (5) @(negedge clk_50);
    vectors++;
    if (first != 0 || nd != 0 || mem[12'h0A5] !== ref_mem[12'h0A5]) begin
      miscompares++;
      $display("FAIL post_reset: first p%0d stray done %0d flag %b, required p0 0 %b",
               first, nd, mem[12'h0A5], ref_mem[12'h0A5]);
    end
    ref_last = 0;
    access(0, 12'h0B0, 1'b1, 1'b0, tg, tw, td, nw, rd);
    ref_mem[12'h0B0] = 1'b0;
    vectors++;
    if (nw != 1 || rd !== 1'b1 || flag_count !== (AW+1)'(ref_cnt)) begin
      miscompares++;
      $display("FAIL saturate_zero: nwen %0d rdata %b count %0d, required 1 1 0",
               nw, rd, flag_count);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 1'($urandom_range(0, 1));
    test_reset();
    test_clear();
    test_directed();
    test_random();
    test_round_robin();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
